// File: rtl/mips_controller.sv
// Main decode/control unit for the single-issue MIPS datapath.
// Decodes the fetched instruction combinationally and registers every
// control output, so outputs lag Instruction by one rising clock edge.
//
// Ports:
//   Clk         - system clock, rising-edge
//   Rst         - synchronous active-low reset (clears all outputs)
//   Instruction - 32-bit instruction word (op=[31:26], funct=[5:0])
//   ALUOp       - 4-bit ALU operation code
//   ALUSrc      - ALU B operand: 1 = immediate, 0 = rt
//   RegDst      - destination: 1 = rd, 0 = rt
//   Jump        - j-type jump
//   Branch      - beq, taken when ALU result is zero
//   MemRead     - data memory read
//   MemWrite    - data memory write
//   MemToReg    - GPR writeback from memory
//   RegWrite    - GPR write enable
//   WriteHi     - Hi register write enable
//   WriteLo     - Lo register write enable
//   HiOrLo      - Hi/Lo read select: 1 = Hi, 0 = Lo
//   HiLoReg     - GPR writeback from the Hi/Lo read path
module mips_controller (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instruction,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        WriteHi,
    output logic        WriteLo,
    output logic        HiOrLo,
    output logic        HiLoReg
);

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_NOR   = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_MUL   = 4'b1001;
    localparam logic [3:0] ALU_MULT  = 4'b1010;
    localparam logic [3:0] ALU_MULTU = 4'b1011;
    localparam logic [3:0] ALU_PASSA = 4'b1100;
    localparam logic [3:0] ALU_LUI   = 4'b1101;
    localparam logic [3:0] ALU_SLTU  = 4'b1110;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       write_hi;
        logic       write_lo;
        logic       hi_or_lo;
        logic       hi_lo_reg;
    } ctrl_t;

    logic [5:0] op;
    logic [5:0] funct;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;

    assign op    = Instruction[31:26];
    assign funct = Instruction[5:0];

    // Instruction decode; anything not matched stays at the all-zero NOP.
    always_comb begin
        ctrl_d = '0;
        unique case (op)
            6'h00: begin
                // R-type: default to ALU writeback into rd, then specialise.
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                case (funct)
                    6'h20, 6'h21: ctrl_d.alu_op = ALU_ADD;
                    6'h22, 6'h23: ctrl_d.alu_op = ALU_SUB;
                    6'h24:        ctrl_d.alu_op = ALU_AND;
                    6'h25:        ctrl_d.alu_op = ALU_OR;
                    6'h26:        ctrl_d.alu_op = ALU_XOR;
                    6'h27:        ctrl_d.alu_op = ALU_NOR;
                    6'h2A:        ctrl_d.alu_op = ALU_SLT;
                    6'h2B:        ctrl_d.alu_op = ALU_SLTU;
                    6'h00:        ctrl_d.alu_op = ALU_SLL;
                    6'h02:        ctrl_d.alu_op = ALU_SRL;
                    6'h18, 6'h19: begin
                        ctrl_d.alu_op    = (funct == 6'h18) ? ALU_MULT : ALU_MULTU;
                        ctrl_d.reg_dst   = 1'b0;
                        ctrl_d.reg_write = 1'b0;
                        ctrl_d.write_hi  = 1'b1;
                        ctrl_d.write_lo  = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        ctrl_d.alu_op    = ALU_ADD;
                        ctrl_d.hi_lo_reg = 1'b1;
                        ctrl_d.hi_or_lo  = (funct == 6'h10);
                    end
                    6'h11, 6'h13: begin
                        ctrl_d.alu_op    = ALU_PASSA;
                        ctrl_d.reg_dst   = 1'b0;
                        ctrl_d.reg_write = 1'b0;
                        ctrl_d.write_hi  = (funct == 6'h11);
                        ctrl_d.write_lo  = (funct == 6'h13);
                    end
                    default:      ctrl_d = '0;
                endcase
            end
            6'h1C: begin
                if (funct == 6'h02) begin
                    ctrl_d.alu_op    = ALU_MUL;
                    ctrl_d.reg_dst   = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
                // Immediate ALU ops and loads write rt with B = immediate.
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                case (op)
                    6'h0A:   ctrl_d.alu_op = ALU_SLT;
                    6'h0B:   ctrl_d.alu_op = ALU_SLTU;
                    6'h0C:   ctrl_d.alu_op = ALU_AND;
                    6'h0D:   ctrl_d.alu_op = ALU_OR;
                    6'h0E:   ctrl_d.alu_op = ALU_XOR;
                    6'h0F:   ctrl_d.alu_op = ALU_LUI;
                    default: ctrl_d.alu_op = ALU_ADD;
                endcase
                if (op == 6'h23) begin
                    ctrl_d.mem_read   = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                end
            end
            6'h2B: begin
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            6'h04: begin
                ctrl_d.alu_op = ALU_SUB;
                ctrl_d.branch = 1'b1;
            end
            6'h02: ctrl_d.jump = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // Output register; reset wins over decode.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ALUOp    = ctrl_q.alu_op;
    assign ALUSrc   = ctrl_q.alu_src;
    assign RegDst   = ctrl_q.reg_dst;
    assign Jump     = ctrl_q.jump;
    assign Branch   = ctrl_q.branch;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign MemToReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign WriteHi  = ctrl_q.write_hi;
    assign WriteLo  = ctrl_q.write_lo;
    assign HiOrLo   = ctrl_q.hi_or_lo;
    assign HiLoReg  = ctrl_q.hi_lo_reg;

endmodule

// File: tb/tb_mips_controller.sv
// Table-driven bench for mips_controller. Expected control words are
// hand-computed constants, packed as
// {ALUOp[3:0], ALUSrc, RegDst, Jump, Branch, MemRead, MemWrite, MemToReg,
//  RegWrite, WriteHi, WriteLo, HiOrLo, HiLoReg}.
module tb_mips_controller;

    logic        Clk;
    logic        Rst;
    logic [31:0] Instruction;
    logic [3:0]  ALUOp;
    logic        ALUSrc, RegDst, Jump, Branch, MemRead, MemWrite, MemToReg;
    logic        RegWrite, WriteHi, WriteLo, HiOrLo, HiLoReg;

    int checks = 0;
    int errors = 0;

    mips_controller dut (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .Jump(Jump),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .WriteHi(WriteHi),
        .WriteLo(WriteLo), .HiOrLo(HiOrLo), .HiLoReg(HiLoReg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] instr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] outs();
        return {ALUOp, ALUSrc, RegDst, Jump, Branch, MemRead, MemWrite, MemToReg,
                RegWrite, WriteHi, WriteLo, HiOrLo, HiLoReg};
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        checks++;
        if (outs() !== exp || (RegWrite && MemWrite) || (MemRead && MemWrite)) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, outs(), exp);
        end
    endtask

    task automatic add_vec(input string n, input logic r, input logic [31:0] i,
                           input logic [3:0] a, input logic [11:0] f);
        vec_t v;
        v.name = n; v.rst = r; v.instr = i; v.exp = {a, f};
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [31:0] i);
        @(negedge Clk);
        Rst = r;
        Instruction = i;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //                                         ALUOp    SDJB_RWMG_HLOR
        add_vec("rst0",     0, 32'h01095020, 4'b0000, 12'b0000_0000_0000);
        add_vec("rst1",     0, 32'h01095020, 4'b0000, 12'b0000_0000_0000);
        add_vec("add",      1, 32'h01095020, 4'b0000, 12'b0100_0001_0000);
        add_vec("mul",      1, 32'h712A4002, 4'b1001, 12'b0100_0001_0000);
        add_vec("slt",      1, 32'h012A402A, 4'b0110, 12'b0100_0001_0000);
        add_vec("mfhi",     1, 32'h00004010, 4'b0000, 12'b0100_0001_0011);
        add_vec("mtlo",     1, 32'h01000013, 4'b1100, 12'b0000_0000_0100);
        add_vec("mthi",     1, 32'h01000011, 4'b1100, 12'b0000_0000_1000);
        add_vec("mflo",     1, 32'h00004012, 4'b0000, 12'b0100_0001_0001);
        add_vec("mult",     1, 32'h01090018, 4'b1010, 12'b0000_0000_1100);
        add_vec("multu",    1, 32'h01090019, 4'b1011, 12'b0000_0000_1100);
        add_vec("lw",       1, 32'h8D280004, 4'b0000, 12'b1000_1011_0000);
        add_vec("sw",       1, 32'hAD280004, 4'b0000, 12'b1000_0100_0000);
        add_vec("beq",      1, 32'h1109FFFF, 4'b0001, 12'b0001_0000_0000);
        add_vec("j",        1, 32'h08000010, 4'b0000, 12'b0010_0000_0000);
        add_vec("allones",  1, 32'hFFFFFFFF, 4'b0000, 12'b0000_0000_0000);
        add_vec("sub",      1, 32'h01095022, 4'b0001, 12'b0100_0001_0000);
        add_vec("subu",     1, 32'h01095023, 4'b0001, 12'b0100_0001_0000);
        add_vec("and",      1, 32'h01095024, 4'b0010, 12'b0100_0001_0000);
        add_vec("or",       1, 32'h01095025, 4'b0011, 12'b0100_0001_0000);
        add_vec("xor",      1, 32'h01095026, 4'b0101, 12'b0100_0001_0000);
        add_vec("nor",      1, 32'h01095027, 4'b0100, 12'b0100_0001_0000);
        add_vec("sltu",     1, 32'h0109502B, 4'b1110, 12'b0100_0001_0000);
        add_vec("addu",     1, 32'h01095021, 4'b0000, 12'b0100_0001_0000);
        add_vec("sll0",     1, 32'h00000000, 4'b0111, 12'b0100_0001_0000);
        add_vec("srl",      1, 32'h00084042, 4'b1000, 12'b0100_0001_0000);
        add_vec("badfn",    1, 32'h0109503F, 4'b0000, 12'b0000_0000_0000);
        add_vec("bad1c",    1, 32'h71000000, 4'b0000, 12'b0000_0000_0000);
        add_vec("addi",     1, 32'h21090005, 4'b0000, 12'b1000_0001_0000);
        add_vec("addiu",    1, 32'h25090005, 4'b0000, 12'b1000_0001_0000);
        add_vec("slti",     1, 32'h2909000A, 4'b0110, 12'b1000_0001_0000);
        add_vec("sltiu",    1, 32'h2D09000A, 4'b1110, 12'b1000_0001_0000);
        add_vec("andi",     1, 32'h310900FF, 4'b0010, 12'b1000_0001_0000);
        add_vec("ori",      1, 32'h35090001, 4'b0011, 12'b1000_0001_0000);
        add_vec("xori",     1, 32'h39090001, 4'b0101, 12'b1000_0001_0000);
        add_vec("lui",      1, 32'h3C081234, 4'b1101, 12'b1000_0001_0000);
        // Reset asserted mid-stream on a load, released, then held.
        add_vec("lw_pre",   1, 32'h8D280004, 4'b0000, 12'b1000_1011_0000);
        add_vec("lw_rst",   0, 32'h8D280004, 4'b0000, 12'b0000_0000_0000);
        add_vec("lw_rel",   1, 32'h8D280004, 4'b0000, 12'b1000_1011_0000);
        add_vec("hold0",    0, 32'h01090018, 4'b0000, 12'b0000_0000_0000);
        add_vec("hold1",    0, 32'h01090018, 4'b0000, 12'b0000_0000_0000);

        Rst = 1'b0;
        Instruction = 32'h0;

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].instr);
            check(vecs[k].name, vecs[k].exp);
        end

        // Latency: changing Instruction between edges must not move outputs.
        step(1'b1, 32'h8D280004);
        check("lat_lw", 16'b0000_1000_1011_0000);
        @(negedge Clk);
        Instruction = 32'h08000010;
        #2;
        check("lat_hold", 16'b0000_1000_1011_0000);
        @(posedge Clk);
        #1;
        check("lat_j", 16'b0000_0010_0000_0000);

        // Back-to-back writes to Hi/Lo then illegal opcode clears them.
        step(1'b1, 32'h01090019);
        check("seq_multu", 16'b1011_0000_0000_1100);
        step(1'b1, 32'hFC000000);
        check("seq_illegal", 16'b0000_0000_0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute timeout so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_controller.md
Name: mips_controller

Overview:
- Main decode/control unit of the single-issue MIPS datapath.
- Takes the 32-bit fetched instruction and produces ALU operation, mux selects, memory strobes and register/Hi/Lo write enables.
- Outputs are registered: one clock of latency, synchronous active-low reset.
- Sits between instruction memory and the datapath muxes, register file, ALU, Hi/Lo registers and data memory.

Parameters:
- None.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  synchronous active-low reset.
- Instruction  input  32  instruction word; op=[31:26], funct=[5:0].
- ALUOp  output  4  ALU operation code (encoding below).
- ALUSrc  output  1  1 = ALU B operand is the immediate; 0 = rt.
- RegDst  output  1  1 = destination is rd; 0 = destination is rt.
- Jump  output  1  j-type jump.
- Branch  output  1  beq; taken when the ALU result is zero.
- MemRead  output  1  data memory read (lw).
- MemWrite  output  1  data memory write (sw).
- MemToReg  output  1  1 = GPR writeback data comes from memory.
- RegWrite  output  1  GPR write enable.
- WriteHi  output  1  Hi register write enable.
- WriteLo  output  1  Lo register write enable.
- HiOrLo  output  1  Hi/Lo read select: 1 = Hi, 0 = Lo.
- HiLoReg  output  1  1 = GPR writeback data comes from the Hi/Lo read path.

Behaviour:
- ALUOp encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOR, 0101 XOR, 0110 SLT, 0111 SLL
  - 1000 SRL, 1001 MUL (low 32 bits), 1010 MULT (signed 64-bit to Hi:Lo), 1011 MULTU
  - 1100 PASSA (rs passthrough), 1101 LUI, 1110 SLTU, 1111 reserved (never driven).
- Decode is combinational from Instruction. All outputs are registered on the rising Clk edge, so outputs reflect the instruction present before the previous edge (1-cycle latency).
- Rst=0 at a rising edge: every output becomes 0 (ALUOp=0000). Rst has priority over decode. Reset held mid-stream keeps the outputs at 0.
- Any output not listed for an instruction below is 0.
- op=000000 (R-type), all with RegDst=1 and RegWrite=1 unless noted:
  - add 0x20 / addu 0x21 -> ADD; sub 0x22 / subu 0x23 -> SUB.
  - and 0x24 AND; or 0x25 OR; xor 0x26 XOR; nor 0x27 NOR.
  - slt 0x2A SLT; sltu 0x2B SLTU; sll 0x00 SLL; srl 0x02 SRL.
  - mult 0x18 -> MULT with WriteHi=1, WriteLo=1, RegWrite=0, RegDst=0.
  - multu 0x19 -> MULTU, same enables as mult.
  - mfhi 0x10 -> HiLoReg=1, HiOrLo=1, ALUOp=ADD.
  - mflo 0x12 -> HiLoReg=1, HiOrLo=0, ALUOp=ADD.
  - mthi 0x11 -> PASSA, WriteHi=1, RegWrite=0, RegDst=0.
  - mtlo 0x13 -> PASSA, WriteLo=1, RegWrite=0, RegDst=0.
  - Unlisted funct: illegal.
- op=011100 with funct=000010 (mul): MUL, RegDst=1, RegWrite=1. Other funct values: illegal.
- I-type, all with ALUSrc=1 and RegWrite=1 unless noted:
  - addi 0x08 / addiu 0x09 -> ADD; andi 0x0C AND; ori 0x0D OR; xori 0x0E XOR.
  - slti 0x0A SLT; sltiu 0x0B SLTU; lui 0x0F LUI.
  - lw 0x23 -> ADD, MemRead=1, MemToReg=1.
  - sw 0x2B -> ADD, MemWrite=1, RegWrite=0.
- beq 0x04: SUB, Branch=1, ALUSrc=0.
- j 0x02: Jump=1, all enables 0.
- Illegal or unlisted opcodes: all outputs 0 (safe NOP; no write of any kind).
- The all-zero word (sll $0,$0,0) decodes as SLL with RegWrite=1 to $0, which is harmless.
- Never assert RegWrite together with MemWrite. Never assert MemRead together with MemWrite.

Test Plan:
- Rst=0 for 2 edges with Instruction=0x01095020 -> all outputs 0. Release Rst -> after next edge RegDst=1, RegWrite=1, ALUOp=0000.
- 0x712A4002 (mul), then 0x012A402A (slt) on successive edges -> ALUOp=1001, then 0110; RegDst=1 and RegWrite=1 for both; ALUSrc=0 and all Hi/Lo enables 0.
- 0x00004010 (mfhi) -> RegWrite=1, RegDst=1, HiLoReg=1, HiOrLo=1, WriteHi=0, WriteLo=0. 0x01000013 (mtlo) -> WriteLo=1, ALUOp=1100, RegWrite=0, HiLoReg=0.
- 0x8D280004 (lw) -> ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, RegDst=0. 0xAD280004 (sw) -> MemWrite=1, ALUSrc=1, RegWrite=0.
- 0x1109FFFF (beq) -> Branch=1, ALUOp=0001, ALUSrc=0. 0x08000010 (j) -> Jump=1, all other outputs 0.
- 0xFFFFFFFF -> all outputs 0 one edge later. Assert Rst=0 mid-sequence on a lw -> outputs 0 at that edge.
